inst_encoder: RTL and testbench

- Inverse of the immediate generator: packs decoded fields (format, opcode, registers, functs, 32-bit immediate) into a 32-bit RV32I instruction word.
- Scatters immediate bits into the format-specific positions.
- Streams encoded words out with a valid/ready handshake and a byte address, for preloading instruction memory and for self-checking immediate-generator benches.

---
 rtl/riscv_enc_pkg.sv | 44 ++++
 rtl/inst_encoder_imm_pack.sv | 52 +++++
 rtl/inst_encoder.sv | 180 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes, opcodes,
// immediate range limits and the FSM state type.
package riscv_enc_pkg;

  // Instruction format codes as presented on the fmt input
  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_SB = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_UJ = 3'd5;

  // Canonical nop (addi x0,x0,0), emitted for illegal formats
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Base opcodes
  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_SB   = 7'h63;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_JAL  = 7'h6F;

  // Representable immediate ranges (signed byte values)
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -(1 << 20);
  localparam int IMM21_MAX = (1 << 20) - 2;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

  // True for the six defined formats
  function automatic logic fmt_legal(input logic [2:0] f);
    return (f <= FMT_UJ);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// imm_pack: scatters a 32-bit immediate into the instruction-word bit
// positions used by its format and flags immediates the format cannot hold.
// Illegal formats produce an all-zero field and a violation.
module imm_pack
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] imm_field,
  output logic        range_viol
);

  logic signed [31:0] simm;
  assign simm = imm;

  // Per-format scatter and range check
  always_comb begin
    imm_field  = '0;
    range_viol = 1'b0;
    case (fmt)
      FMT_R: begin
        imm_field  = '0;
        range_viol = 1'b0;
      end
      FMT_I: begin
        imm_field  = {imm[11:0], 20'b0};
        range_viol = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      FMT_S: begin
        imm_field  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_viol = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      FMT_SB: begin
        imm_field  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_viol = (simm < IMM13_MIN) || (simm > IMM13_MAX) || imm[0];
      end
      FMT_U: begin
        imm_field  = {imm[31:12], 12'b0};
        range_viol = (imm[11:0] != 12'b0);
      end
      FMT_UJ: begin
        imm_field  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_viol = (simm < IMM21_MIN) || (simm > IMM21_MAX) || imm[0];
      end
      default: begin
        imm_field  = '0;
        range_viol = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into an instruction word and
// streams it out through a one-entry output register with a byte address.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a held word stays stable
// until it is taken. in_ready is high when the register is empty or is
// being drained in the same cycle, which gives one word per cycle.
// Optional macro INST_ENCODER_ROUNDTRIP_EN adds an immediate extractor that
// re-decodes the held word and raises sticky rt_mismatch on disagreement.
module inst_encoder
  import riscv_enc_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              range_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              rt_mismatch
);

  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_RESET = ADDR_W'(START_ADDR);

  enc_state_e        state_q, state_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              range_err_q, range_err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [31:0] imm_field;
  logic        range_viol;
  logic [31:0] enc_word;
  logic        in_hs;
  logic        out_hs;

  imm_pack u_imm_pack (
    .fmt        (fmt),
    .imm        (imm),
    .imm_field  (imm_field),
    .range_viol (range_viol)
  );

  // Merge register/opcode fields with the scattered immediate
  always_comb begin
    enc_word = NOP_INST;
    case (fmt)
      FMT_R:          enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:          enc_word = imm_field | {12'b0, rs1, funct3, rd, opcode};
      FMT_S, FMT_SB:  enc_word = imm_field | {7'b0, rs2, rs1, funct3, 5'b0, opcode};
      FMT_U, FMT_UJ:  enc_word = imm_field | {20'b0, rd, opcode};
      default:        enc_word = NOP_INST;
    endcase
  end

  // Handshakes, next state, address counter and sticky error capture
  always_comb begin
    state_d     = state_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    range_err_d = range_err_q;
    err_addr_d  = err_addr_q;

    out_valid = (state_q == ST_FULL);
    in_ready  = (state_q == ST_EMPTY) | out_ready;
    out_hs    = out_valid & out_ready;
    in_hs     = in_valid & in_ready;

    if (out_hs) begin
      out_addr_d = out_addr_q + ADDR_STEP;
      state_d    = ST_EMPTY;
    end
    if (in_hs) begin
      state_d    = ST_FULL;
      out_inst_d = enc_word;
      // out_addr_d is already the address the new word will carry
      if (range_viol && !range_err_q) begin
        range_err_d = 1'b1;
        err_addr_d  = out_addr_d;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_inst_q  <= '0;
      out_addr_q  <= ADDR_RESET;
      range_err_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      range_err_q <= range_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign range_err = range_err_q;
  assign err_addr  = err_addr_q;

`ifdef INST_ENCODER_ROUNDTRIP_EN
  logic [2:0]  rt_fmt_q, rt_fmt_d;
  logic [31:0] rt_imm_q, rt_imm_d;
  logic        rt_werr_q, rt_werr_d;
  logic        rt_mismatch_q, rt_mismatch_d;
  logic [31:0] ext_imm;
  logic        ext_check;

  // Decode the immediate back out of the held word by its format
  always_comb begin
    ext_imm   = '0;
    ext_check = 1'b1;
    case (rt_fmt_q)
      FMT_I:  ext_imm = {{20{out_inst_q[31]}}, out_inst_q[31:20]};
      FMT_S:  ext_imm = {{20{out_inst_q[31]}}, out_inst_q[31:25], out_inst_q[11:7]};
      FMT_SB: ext_imm = {{19{out_inst_q[31]}}, out_inst_q[31], out_inst_q[7],
                         out_inst_q[30:25], out_inst_q[11:8], 1'b0};
      FMT_U:  ext_imm = {out_inst_q[31:12], 12'b0};
      FMT_UJ: ext_imm = {{11{out_inst_q[31]}}, out_inst_q[31], out_inst_q[19:12],
                         out_inst_q[20], out_inst_q[30:21], 1'b0};
      default: ext_check = 1'b0;
    endcase
  end

  // Track the held word's source fields and accumulate mismatches
  always_comb begin
    rt_fmt_d      = rt_fmt_q;
    rt_imm_d      = rt_imm_q;
    rt_werr_d     = rt_werr_q;
    rt_mismatch_d = rt_mismatch_q;
    if ((state_q == ST_FULL) && ext_check && !rt_werr_q && (ext_imm != rt_imm_q)) begin
      rt_mismatch_d = 1'b1;
    end
    if (in_hs) begin
      rt_fmt_d  = fmt;
      rt_imm_d  = imm;
      rt_werr_d = range_viol;
    end
  end

  // Round-trip registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rt_fmt_q      <= FMT_R;
      rt_imm_q      <= '0;
      rt_werr_q     <= 1'b0;
      rt_mismatch_q <= 1'b0;
    end else begin
      rt_fmt_q      <= rt_fmt_d;
      rt_imm_q      <= rt_imm_d;
      rt_werr_q     <= rt_werr_d;
      rt_mismatch_q <= rt_mismatch_d;
    end
  end

  assign rt_mismatch = rt_mismatch_q;
`else
  assign rt_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder with a field-arithmetic reference model
// and a one-deep expected-word queue standing in for the output register.
module tb_inst_encoder;

  localparam int ADDR_W = 4;
  localparam int AMOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        fmt = '0;
  logic [6:0]        opcode = '0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [31:0]       imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              range_err;
  logic [ADDR_W-1:0] err_addr;
  logic              rt_mismatch;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          m_addr;
  bit          m_err;
  int          m_err_addr;

  inst_encoder #(.ADDR_W(ADDR_W), .START_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .range_err(range_err), .err_addr(err_addr),
    .rt_mismatch(rt_mismatch)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder built from shifted/masked field values
  function automatic void model_enc(input logic [2:0] f, input logic [6:0] op,
                                    input logic [4:0] d, input logic [4:0] s1,
                                    input logic [4:0] s2, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] im,
                                    output logic [31:0] w, output bit err);
    logic [31:0] o, dd, a, b, c, g;
    int si;
    o = 32'(op); dd = 32'(d) << 7; a = 32'(s1) << 15; b = 32'(s2) << 20;
    c = 32'(f3) << 12; g = 32'(f7) << 25; si = im;
    err = 0;
    case (f)
      3'd0: w = g | b | a | c | dd | o;
      3'd1: begin
        w = ((im & 32'hFFF) << 20) | a | c | dd | o;
        err = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        w = (((im >> 5) & 127) << 25) | b | a | c | ((im & 31) << 7) | o;
        err = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | b | a | c |
            (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | o;
        err = (si < -4096) || (si > 4094) || ((si & 1) != 0);
      end
      3'd4: begin
        w = (im & 32'hFFFF_F000) | dd | o;
        err = (im & 32'hFFF) != 0;
      end
      3'd5: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) |
            (((im >> 11) & 1) << 20) | (((im >> 12) & 255) << 12) | dd | o;
        err = (si < -(1 << 20)) || (si > (1 << 20) - 2) || ((si & 1) != 0);
      end
      default: begin
        w = 32'h0000_0013;
        err = 1;
      end
    endcase
  endfunction

  // One clock: check outputs against the model, advance the model, clock
  task automatic step();
    logic [31:0] w;
    bit          e;
    bit          exp_rdy;
    #1;
    exp_rdy = (exp_q.size() == 0) || out_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_inst", out_inst, exp_q[0]);
      check("out_addr", 32'(out_addr), 32'(m_addr));
    end
    check("range_err", 32'(range_err), 32'(m_err));
    check("err_addr", 32'(err_addr), 32'(m_err_addr));
    check("rt_mismatch", 32'(rt_mismatch), 32'd0);
    if (exp_q.size() != 0 && out_ready) begin
      void'(exp_q.pop_front());
      m_addr = (m_addr + 4) % AMOD;
    end
    if (in_valid && exp_rdy) begin
      model_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, w, e);
      exp_q.push_back(w);
      if (e && !m_err) begin
        m_err = 1;
        m_err_addr = m_addr;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_addr = 0;
    m_err = 0;
    m_err_addr = 0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    check("rst_rt", 32'(rt_mismatch), 32'd0);
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
    in_valid = 1'b1; fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  function automatic logic [31:0] rand_imm();
    int pick;
    int edges[12];
    edges = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
              -1048576, 1048574, 1048576, 32'h12345000};
    pick = $urandom_range(0, 3);
    case (pick)
      0: return 32'($urandom_range(0, 127)) - 32'd64;
      1: return 32'(edges[$urandom_range(0, 11)]);
      2: return $urandom;
      default: return 32'($urandom_range(0, 4095)) * 32'd2 - 32'd4096;
    endcase
  endfunction

  logic [ADDR_W-1:0] saved_err;
  logic [31:0]       held;

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_out_inst", out_inst, 32'd0);

    // add x30,x10,x30
    out_ready = 1'b1;
    set_req(3'd0, 7'h33, 5'd30, 5'd10, 5'd30, 3'd0, 7'd0, 32'd0);
    step();
    in_valid = 1'b0;
    check("add_word", out_inst, 32'h01e50f33);
    check("add_addr", 32'(out_addr), 32'd0);
    step();

    // addi then sw back to back
    do_reset();
    out_ready = 1'b1;
    set_req(3'd1, 7'h13, 5'd30, 5'd10, 5'd0, 3'd0, 7'd0, 32'd8);
    step();
    check("addi_word", out_inst, 32'h00850f13);
    check("addi_addr", 32'(out_addr), 32'd0);
    set_req(3'd2, 7'h23, 5'd0, 5'd30, 5'd31, 3'd2, 7'd0, 32'd10);
    step();
    check("sw_word", out_inst, 32'h01ff2523);
    check("sw_addr", 32'(out_addr), 32'd4);
    check("sw_valid", 32'(out_valid), 32'd1);

    // beq, then misaligned and out-of-range branches
    set_req(3'd3, 7'h63, 5'd0, 5'd30, 5'd31, 3'd0, 7'd0, 32'd10);
    step();
    check("beq_word", out_inst, 32'h01ff0563);
    set_req(3'd3, 7'h63, 5'd0, 5'd30, 5'd31, 3'd0, 7'd0, 32'd11);
    step();
    check("sb11_err", 32'(range_err), 32'd1);
    check("sb11_err_addr", 32'(err_addr), 32'(out_addr));
    saved_err = out_addr;
    set_req(3'd3, 7'h63, 5'd0, 5'd30, 5'd31, 3'd0, 7'd0, 32'd5000);
    step();
    check("sb5000_err_addr", 32'(err_addr), 32'(saved_err));

    // backpressure for three cycles, then release
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd100);
    held = out_inst;
    for (int i = 0; i < 3; i++) step();
    check("bp_hold_inst", out_inst, held);
    out_ready = 1'b1;
    step();
    check("bp_release", out_inst, 32'h06410093);

    // illegal format emits nop
    set_req(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_FFFF);
    step();
    check("illegal_nop", out_inst, 32'h0000_0013);
    in_valid = 1'b0;
    step();

    // reset while holding a stalled word
    out_ready = 1'b0;
    set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
    step();
    step();
    do_reset();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0) begin
        set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
      end else begin
        in_valid = 1'b0;
      end
      if (n == 300) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
